// File: rtl/gen_edge_req_queue.sv
// -----------------------------------------------------------------------------
// gen_edge_req_queue
//
// Purpose:
//   Turns single-cycle rising-edge pulses from the upstream edge detector
//   into a level request/acknowledge handshake for the control FSM.
//   After an edge is accepted, a holdoff window of HOLDOFF cycles follows.
//   Edges that arrive inside that window are treated as bounce and dropped.
//   Accepted edges are queued in a saturating pending counter.
//   A sticky overflow flag records that an accepted edge was lost because
//   the queue was already full.
//
// Parameters:
//   PEND_W   pending counter width; max queued edges = 2**PEND_W-1
//   HOLDOFF  blind cycles after an accepted edge (0 disables the holdoff)
//   HOLD_W   holdoff counter width, must be able to hold HOLDOFF
//
// Ports:
//   clk       in   system clock, all state on posedge
//   n_rst     in   asynchronous active-low reset
//   edge_in   in   single-cycle edge pulse from the edge detector
//   ack       in   consumer acknowledges one request (only honoured while req=1)
//   clear     in   synchronous flush of queue, holdoff and overflow
//   req       out  high while pending != 0
//   pending   out  number of queued, unacknowledged edges
//   overflow  out  sticky: an accepted edge was lost because the queue was full
//   holdoff   out  high while the holdoff counter is non-zero
//   dropped   out  one-cycle registered pulse: edge_in arrived during holdoff
// -----------------------------------------------------------------------------
module gen_edge_req_queue #(
   parameter int PEND_W  = 3,
   parameter int HOLDOFF = 4,
   parameter int HOLD_W  = 3
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              edge_in,
   input  logic              ack,
   input  logic              clear,
   output logic              req,
   output logic [PEND_W-1:0] pending,
   output logic              overflow,
   output logic              holdoff,
   output logic              dropped
);

   typedef enum logic {
      ST_READY = 1'b0,
      ST_HOLD  = 1'b1
   } hold_state_e;

   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   // State registers
   hold_state_e       state_q, state_d;
   logic [HOLD_W-1:0] hcnt_q,  hcnt_d;
   logic [PEND_W-1:0] pend_q,  pend_d;
   logic              ovf_q,   ovf_d;
   logic              drop_q,  drop_d;

   // Qualified events
   logic acc;
   logic dec;
   logic pend_full;

   // An edge is only accepted while the holdoff counter is idle.
   // The state register mirrors (hcnt_q != 0). Decoding the counter
   // directly keeps acceptance independent of the state encoding.
   assign acc       = edge_in && (hcnt_q == '0);
   assign dec       = ack && (pend_q != '0);
   assign pend_full = (pend_q == PEND_MAX);

   // ---------------------------------------------------------------------------
   // Holdoff counter / dropped pulse next state
   // ---------------------------------------------------------------------------
   always_comb begin
      hcnt_d = hcnt_q;
      drop_d = 1'b0;
      if (clear) begin
         hcnt_d = '0;
         drop_d = 1'b0;
      end else if (hcnt_q != '0) begin
         // Blind window: count down, never reload on a bouncing edge.
         hcnt_d = hcnt_q - HOLD_ONE;
         drop_d = edge_in;
      end else if (edge_in) begin
         // With HOLDOFF=0 this loads zero and the FSM stays READY.
         hcnt_d = HOLD_LOAD;
      end
   end

   always_comb begin
      state_d = (hcnt_d != '0) ? ST_HOLD : ST_READY;
   end

   // ---------------------------------------------------------------------------
   // Pending counter / overflow next state
   // ---------------------------------------------------------------------------
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (clear) begin
         pend_d = '0;
         ovf_d  = 1'b0;
      end else if (acc && !dec) begin
         if (pend_full) begin
            // Saturate and remember that an edge was lost.
            pend_d = PEND_MAX;
            ovf_d  = 1'b1;
         end else begin
            pend_d = pend_q + PEND_ONE;
         end
      end else if (dec && !acc) begin
         pend_d = pend_q - PEND_ONE;
      end
      // When acc and dec coincide, one edge enters and one leaves.
      // The count is unchanged, and there is no overflow even at max.
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_READY;
         hcnt_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // All outputs are decodes of registered state only. There is no
   // combinational path from edge_in, ack or clear to any output.
   assign pending  = pend_q;
   assign req      = (pend_q != '0);
   assign overflow = ovf_q;
   assign holdoff  = (state_q == ST_HOLD);
   assign dropped  = drop_q;

endmodule

// File: tb/tb_gen_edge_req_queue.sv
// -----------------------------------------------------------------------------
// tb_gen_edge_req_queue
//
// Directed testbench for gen_edge_req_queue using the default parameters
// (PEND_W=3, HOLDOFF=4, HOLD_W=3).
// Inputs are driven 1 ns after a rising edge, so they are sampled by the
// next rising edge. Outputs are checked 1 ns after the rising edge that
// updated them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gen_edge_req_queue;

   localparam int PEND_W  = 3;
   localparam int HOLDOFF = 4;
   localparam int HOLD_W  = 3;

   logic              clk;
   logic              n_rst;
   logic              edge_in;
   logic              ack;
   logic              clear;
   logic              req;
   logic [PEND_W-1:0] pending;
   logic              overflow;
   logic              holdoff;
   logic              dropped;

   int tests_run;
   int tests_failed;

   gen_edge_req_queue #(
      .PEND_W  (PEND_W),
      .HOLDOFF (HOLDOFF),
      .HOLD_W  (HOLD_W)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .edge_in  (edge_in),
      .ack      (ack),
      .clear    (clear),
      .req      (req),
      .pending  (pending),
      .overflow (overflow),
      .holdoff  (holdoff),
      .dropped  (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_edge();
      edge_in = 1'b1;
      tick();
      edge_in = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Accepted edge followed by enough idle cycles for the holdoff to expire.
   task automatic spaced_edge();
      pulse_edge();
      repeat (5) tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      n_rst   = 1'b0;
      edge_in = 1'b0;
      ack     = 1'b0;
      clear   = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_pending",  32'(pending),  0);
      chk("rst_req",      32'(req),      0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_holdoff",  32'(holdoff),  0);
      chk("rst_dropped",  32'(dropped),  0);
      n_rst = 1'b1;
      repeat (2) tick();

      // T1: single edge, then acknowledge
      pulse_edge();
      chk("t1_pending",  32'(pending), 1);
      chk("t1_req",      32'(req),     1);
      chk("t1_holdoff",  32'(holdoff), 1);
      repeat (4) tick();
      chk("t1_holdoff_end", 32'(holdoff), 0);
      pulse_ack();
      chk("t1_ack_pending", 32'(pending), 0);
      chk("t1_ack_req",     32'(req),     0);
      pulse_ack();
      chk("t1_no_underflow", 32'(pending), 0);
      chk("t1_no_underflow_req", 32'(req), 0);

      // T2: bounce inside holdoff is dropped; edge right after is accepted
      pulse_edge();                     // accepted at posedge N
      chk("t2_first", 32'(pending), 1);
      tick();                           // posedge N+1
      pulse_edge();                     // posedge N+2, inside holdoff
      chk("t2_drop1",      32'(dropped), 1);
      chk("t2_drop1_pend", 32'(pending), 1);
      tick();                           // posedge N+3
      chk("t2_drop_pulse_end", 32'(dropped), 0);
      chk("t2_still_hold",     32'(holdoff), 1);
      pulse_edge();                     // posedge N+4, last blind cycle
      chk("t2_drop2",      32'(dropped), 1);
      chk("t2_drop2_pend", 32'(pending), 1);
      chk("t2_hold_done",  32'(holdoff), 0);
      pulse_edge();                     // posedge N+5, accepted
      chk("t2_second",       32'(pending), 2);
      chk("t2_second_nodrop", 32'(dropped), 0);
      chk("t2_second_hold",  32'(holdoff), 1);
      pulse_clear();
      chk("t2_clear_pend", 32'(pending), 0);
      chk("t2_clear_hold", 32'(holdoff), 0);

      // T3: saturation and sticky overflow
      for (int i = 0; i < 7; i++) spaced_edge();
      chk("t3_seven",    32'(pending),  7);
      chk("t3_no_ovf",   32'(overflow), 0);
      spaced_edge();
      chk("t3_sat",      32'(pending),  7);
      chk("t3_ovf",      32'(overflow), 1);
      chk("t3_req",      32'(req),      1);
      pulse_ack();
      chk("t3_ack_dec",  32'(pending),  6);
      chk("t3_ovf_sticky", 32'(overflow), 1);
      pulse_clear();
      chk("t3_clear_ovf", 32'(overflow), 0);

      // T4: accepted edge and ack in the same cycle
      for (int i = 0; i < 3; i++) spaced_edge();
      chk("t4_three", 32'(pending), 3);
      edge_in = 1'b1;
      ack     = 1'b1;
      tick();
      edge_in = 1'b0;
      ack     = 1'b0;
      chk("t4_same",     32'(pending),  3);
      chk("t4_no_ovf",   32'(overflow), 0);
      chk("t4_hold",     32'(holdoff),  1);
      pulse_ack();                      // ack still works during holdoff
      chk("t4_ack_in_hold", 32'(pending), 2);
      repeat (4) tick();
      // Fill to max, then edge and ack together at max: no overflow
      for (int i = 0; i < 5; i++) spaced_edge();
      chk("t4_full", 32'(pending), 7);
      edge_in = 1'b1;
      ack     = 1'b1;
      tick();
      edge_in = 1'b0;
      ack     = 1'b0;
      chk("t4_full_same",   32'(pending),  7);
      chk("t4_full_no_ovf", 32'(overflow), 0);
      repeat (4) tick();

      // T5: pending=5 with overflow set, clear with a concurrent edge
      spaced_edge();                    // overflow at max
      chk("t5_ovf", 32'(overflow), 1);
      pulse_ack();
      pulse_ack();
      chk("t5_five", 32'(pending), 5);
      edge_in = 1'b1;
      clear   = 1'b1;
      tick();
      edge_in = 1'b0;
      clear   = 1'b0;
      chk("t5_pend", 32'(pending),  0);
      chk("t5_req",  32'(req),      0);
      chk("t5_ovf_clr", 32'(overflow), 0);
      chk("t5_hold", 32'(holdoff),  0);
      tick();
      chk("t5_edge_discarded", 32'(pending), 0);

      // T6: async reset during holdoff with pending=2
      spaced_edge();
      pulse_edge();
      chk("t6_pend2", 32'(pending), 2);
      chk("t6_hold",  32'(holdoff), 1);
      #1;
      n_rst = 1'b0;
      #1;
      chk("t6_rst_pend",  32'(pending),  0);
      chk("t6_rst_req",   32'(req),      0);
      chk("t6_rst_hold",  32'(holdoff),  0);
      chk("t6_rst_ovf",   32'(overflow), 0);
      chk("t6_rst_drop",  32'(dropped),  0);
      tick();
      n_rst = 1'b1;
      tick();
      pulse_edge();
      chk("t6_after_rst", 32'(pending), 1);
      chk("t6_after_rst_req", 32'(req), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
